// File: rtl/invaders_pkg.sv
// -----------------------------------------------------------------------------
// invaders_pkg
// Shared types and default constants for the invader formation logic.
//   march_state_t : formation controller states
//   dir_t         : horizontal march direction
//   NUM_INVADERS / INVADER_WIDTH / X_RANGE : defaults shared with the display
//   step_period() : frames between march steps for a given kill count
// -----------------------------------------------------------------------------
package invaders_pkg;

    localparam int NUM_INVADERS  = 10;
    localparam int INVADER_WIDTH = 16;
    localparam int X_RANGE       = 160;

    typedef enum logic [1:0] {
        IDLE,
        MARCH,
        CLEARED,
        LANDED
    } march_state_t;

    typedef enum logic {
        DIR_RIGHT,
        DIR_LEFT
    } dir_t;

    // period = max(floor_val, base - speedup*kills). Evaluated as signed
    // 16-bit so a large kill count goes negative and clamps, rather than
    // wrapping to a huge unsigned period.
    function automatic logic [15:0] step_period(
        input int         base,
        input int         speedup,
        input int         floor_val,
        input logic [4:0] kills
    );
        logic signed [15:0] raw;
        raw = signed'(16'(base)) - signed'(16'(speedup * int'(kills)));
        if (raw < signed'(16'(floor_val))) begin
            raw = signed'(16'(floor_val));
        end
        return unsigned'(raw);
    endfunction

endpackage

// File: rtl/invader_march_ctrl_frame_tick_gen.sv
// -----------------------------------------------------------------------------
// frame_tick_gen
// Detects the rising edge of vblnk (one tick per frame) and counts ticks while
// the formation is marching. step_o is asserted combinationally in the tick
// cycle that completes a step period; the count then restarts from zero.
//   clk, rst_n   : clock, asynchronous active-low reset
//   vblnk_i      : vertical blanking from the timing stage
//   game_start_i : clears the frame count
//   run_i        : formation is marching; count only while high
//   period_i     : current step period in frames
//   step_o       : march step happens this cycle
// -----------------------------------------------------------------------------
module frame_tick_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vblnk_i,
    input  logic        game_start_i,
    input  logic        run_i,
    input  logic [15:0] period_i,
    output logic        step_o
);

    logic        vblnk_q;
    logic        tick;
    logic [15:0] frame_cnt_q;
    logic [15:0] frame_cnt_d;
    logic [16:0] cnt_inc;

    assign tick    = vblnk_i & ~vblnk_q;
    assign cnt_inc = {1'b0, frame_cnt_q} + 17'd1;

    // >= rather than ==: if a kill shortens the period below the frames
    // already counted, the step fires on the next tick instead of waiting
    // for the counter to wrap.
    assign step_o = run_i & ~game_start_i & tick & (cnt_inc >= {1'b0, period_i});

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (game_start_i) begin
            frame_cnt_d = '0;
        end else if (run_i && tick) begin
            frame_cnt_d = step_o ? 16'd0 : cnt_inc[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblnk_q     <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            vblnk_q     <= vblnk_i;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule

// File: rtl/invader_march_ctrl.sv
// -----------------------------------------------------------------------------
// invader_march_ctrl
// Marches the invader formation left/right one step per period, descending and
// reversing at each playfield edge, clears invaders on hit reports and shortens
// the step period as invaders die. Position outputs only change in the vblank
// tick cycle so the display never tears.
//   clk65MHz, rst_n     : pixel clock, asynchronous active-low reset
//   vblnk               : vertical blanking; rising edge = new frame
//   game_start          : one-cycle pulse, (re)starts the wave
//   hit_valid/hit_index : one-cycle hit report for invader hit_index
//   xpos, ypos          : formation offset
//   invader_enable      : alive mask
//   wave_cleared        : sticky, all invaders dead
//   invaders_landed     : sticky, ypos reached Y_LIMIT
//   step_pulse          : one-cycle pulse per march step
// -----------------------------------------------------------------------------
module invader_march_ctrl #(
    parameter int NUM_INVADERS    = invaders_pkg::NUM_INVADERS,
    parameter int X_RANGE         = invaders_pkg::X_RANGE,
    parameter int Y_LIMIT         = 400,
    parameter int STEP_X          = 8,
    parameter int STEP_Y          = 16,
    parameter int FRAMES_PER_STEP = 30,
    parameter int SPEEDUP         = 2,
    parameter int MIN_FRAMES      = 4
) (
    input  logic                    clk65MHz,
    input  logic                    rst_n,
    input  logic                    vblnk,
    input  logic                    game_start,
    input  logic                    hit_valid,
    input  logic [3:0]              hit_index,
    output logic [9:0]              xpos,
    output logic [9:0]              ypos,
    output logic [NUM_INVADERS-1:0] invader_enable,
    output logic                    wave_cleared,
    output logic                    invaders_landed,
    output logic                    step_pulse
);
    import invaders_pkg::*;

    march_state_t            state_q, state_d;
    dir_t                    dir_q, dir_d;
    logic [9:0]              xpos_q, xpos_d;
    logic [9:0]              ypos_q, ypos_d;
    logic [NUM_INVADERS-1:0] enable_q, enable_d;
    logic [4:0]              kills_q, kills_d;
    logic                    cleared_q, cleared_d;
    logic                    landed_q, landed_d;
    logic                    step_q, step_d;

    logic [NUM_INVADERS-1:0] hit_mask;
    logic                    hit_ok;
    logic                    run;
    logic                    step;
    logic [15:0]             period;
    logic [10:0]             x_right;
    logic [10:0]             y_down;
    logic                    descend;
    logic                    will_land;

    // One-hot hit decode; indices >= NUM_INVADERS match no bit and are ignored.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_INVADERS; gi++) begin : g_hit
            assign hit_mask[gi] = hit_valid && (hit_index == 4'(gi));
        end
    endgenerate

    assign hit_ok = |(hit_mask & enable_q);

    // An empty mask in MARCH means the wave is over: no counting, no moves.
    assign run    = (state_q == MARCH) && (enable_q != '0);
    assign period = step_period(FRAMES_PER_STEP, SPEEDUP, MIN_FRAMES, kills_q);

    frame_tick_gen u_tick (
        .clk          (clk65MHz),
        .rst_n        (rst_n),
        .vblnk_i      (vblnk),
        .game_start_i (game_start),
        .run_i        (run),
        .period_i     (period),
        .step_o       (step)
    );

    assign x_right   = {1'b0, xpos_q} + 11'(STEP_X);
    assign y_down    = {1'b0, ypos_q} + 11'(STEP_Y);
    assign descend   = (dir_q == DIR_RIGHT) ? (x_right > 11'(X_RANGE))
                                            : (xpos_q < 10'(STEP_X));
    assign will_land = descend && (y_down >= 11'(Y_LIMIT));

    // State register + datapath registers
    always_ff @(posedge clk65MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dir_q     <= DIR_RIGHT;
            xpos_q    <= '0;
            ypos_q    <= '0;
            enable_q  <= '0;
            kills_q   <= '0;
            cleared_q <= 1'b0;
            landed_q  <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            xpos_q    <= xpos_d;
            ypos_q    <= ypos_d;
            enable_q  <= enable_d;
            kills_q   <= kills_d;
            cleared_q <= cleared_d;
            landed_q  <= landed_d;
            step_q    <= step_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (game_start) begin
            state_d = MARCH;
        end else if (state_q == MARCH) begin
            if (enable_q == '0) begin
                state_d = CLEARED;
            end else if (step && will_land) begin
                state_d = LANDED;
            end
        end
    end

    // Output / datapath next values
    always_comb begin
        dir_d     = dir_q;
        xpos_d    = xpos_q;
        ypos_d    = ypos_q;
        enable_d  = enable_q;
        kills_d   = kills_q;
        cleared_d = cleared_q;
        landed_d  = landed_q;
        step_d    = 1'b0;
        if (game_start) begin
            dir_d     = DIR_RIGHT;
            xpos_d    = '0;
            ypos_d    = '0;
            enable_d  = '1;
            kills_d   = '0;
            cleared_d = 1'b0;
            landed_d  = 1'b0;
        end else if (run) begin
            // A hit and a step may land in the same cycle; both apply and the
            // new kill count affects the next period comparison only.
            if (hit_ok) begin
                enable_d = enable_q & ~hit_mask;
                kills_d  = kills_q + 5'd1;
            end
            if (step) begin
                step_d = 1'b1;
                if (descend) begin
                    ypos_d   = y_down[9:0];
                    dir_d    = (dir_q == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT;
                    landed_d = will_land;
                end else if (dir_q == DIR_RIGHT) begin
                    xpos_d = x_right[9:0];
                end else begin
                    xpos_d = xpos_q - 10'(STEP_X);
                end
            end
        end else if (state_q == MARCH) begin
            cleared_d = 1'b1;
        end
    end

    assign xpos            = xpos_q;
    assign ypos            = ypos_q;
    assign invader_enable  = enable_q;
    assign wave_cleared    = cleared_q;
    assign invaders_landed = landed_q;
    assign step_pulse      = step_q;

endmodule

// File: tb/tb_invader_march_ctrl.sv
// -----------------------------------------------------------------------------
// tb_invader_march_ctrl
// Drives the march controller one cycle at a time. A behavioural model computes
// the expected registered outputs for each cycle and pushes them to a queue;
// they are popped and compared after the clock edge. Table-driven vectors cover
// hit handling and the edge/descent sequence; hand-written sequences cover the
// period speedup, wave clear, landing and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_invader_march_ctrl;
    localparam int N    = 10;
    localparam int XR   = 16;
    localparam int YL   = 32;
    localparam int SX   = 8;
    localparam int SY   = 16;
    localparam int FPS  = 30;
    localparam int SPD  = 2;
    localparam int MINF = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         vblnk = 1'b0;
    logic         game_start = 1'b0;
    logic         hit_valid = 1'b0;
    logic [3:0]   hit_index = 4'd0;
    logic [9:0]   xpos;
    logic [9:0]   ypos;
    logic [N-1:0] invader_enable;
    logic         wave_cleared;
    logic         invaders_landed;
    logic         step_pulse;

    always #5 clk = ~clk;

    invader_march_ctrl #(
        .NUM_INVADERS    (N),
        .X_RANGE         (XR),
        .Y_LIMIT         (YL),
        .STEP_X          (SX),
        .STEP_Y          (SY),
        .FRAMES_PER_STEP (FPS),
        .SPEEDUP         (SPD),
        .MIN_FRAMES      (MINF)
    ) dut (
        .clk65MHz        (clk),
        .rst_n           (rst_n),
        .vblnk           (vblnk),
        .game_start      (game_start),
        .hit_valid       (hit_valid),
        .hit_index       (hit_index),
        .xpos            (xpos),
        .ypos            (ypos),
        .invader_enable  (invader_enable),
        .wave_cleared    (wave_cleared),
        .invaders_landed (invaders_landed),
        .step_pulse      (step_pulse)
    );

    typedef struct packed {
        logic [9:0]   x;
        logic [9:0]   y;
        logic [N-1:0] en;
        logic         clr;
        logic         land;
        logic         stp;
    } obs_t;

    typedef struct {
        logic [3:0]   idx;
        logic [N-1:0] en;
        int           kills;
    } hit_vec_t;

    typedef struct {
        int x;
        int y;
        int land;
    } march_vec_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_count = 0;

    // model state (0 IDLE, 1 MARCH, 2 CLEARED, 3 LANDED; dir 0 right, 1 left)
    int           m_state, m_x, m_y, m_dir, m_cnt, m_kills;
    logic [N-1:0] m_en;
    logic         m_vq, m_clr, m_land, m_stp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_x = 0; m_y = 0; m_dir = 0; m_cnt = 0; m_kills = 0;
        m_en = '0; m_vq = 1'b0; m_clr = 1'b0; m_land = 1'b0; m_stp = 1'b0;
    endtask

    task automatic model_step(input logic vb, input logic gs, input logic hv, input logic [3:0] hi);
        logic        tick;
        int          p;
        int          ns, nx, ny, nd, nc, nk;
        logic [15:0] en16;
        logic        nclr, nland, nstp;
        obs_t        o;
        tick = vb && !m_vq;
        p = FPS - SPD * m_kills;
        if (p < MINF) p = MINF;
        ns = m_state; nx = m_x; ny = m_y; nd = m_dir; nc = m_cnt; nk = m_kills;
        en16 = 16'(m_en); nclr = m_clr; nland = m_land; nstp = 1'b0;
        if (gs) begin
            ns = 1; nx = 0; ny = 0; nd = 0; nc = 0; nk = 0;
            en16 = 16'((1 << N) - 1); nclr = 1'b0; nland = 1'b0;
        end else if (m_state == 1 && m_en == '0) begin
            ns = 2; nclr = 1'b1;
        end else if (m_state == 1) begin
            if (hv && int'(hi) < N && en16[hi]) begin
                en16[hi] = 1'b0;
                nk = m_kills + 1;
            end
            if (tick) begin
                if (m_cnt + 1 >= p) begin
                    nc = 0; nstp = 1'b1;
                    if (m_dir == 0) begin
                        if (m_x + SX > XR) begin ny = m_y + SY; nd = 1; end
                        else nx = m_x + SX;
                    end else begin
                        if (m_x < SX) begin ny = m_y + SY; nd = 0; end
                        else nx = m_x - SX;
                    end
                    if (ny >= YL) begin nland = 1'b1; ns = 3; end
                end else begin
                    nc = m_cnt + 1;
                end
            end
        end
        m_vq = vb; m_state = ns; m_x = nx; m_y = ny; m_dir = nd; m_cnt = nc;
        m_kills = nk; m_en = en16[N-1:0]; m_clr = nclr; m_land = nland; m_stp = nstp;
        o.x = 10'(m_x); o.y = 10'(m_y); o.en = m_en;
        o.clr = m_clr; o.land = m_land; o.stp = m_stp;
        exp_q.push_back(o);
    endtask

    // One clock: drive inputs, predict, clock, compare.
    task automatic cyc(input logic vb, input logic gs, input logic hv, input logic [3:0] hi);
        obs_t got, want;
        vblnk = vb; game_start = gs; hit_valid = hv; hit_index = hi;
        model_step(vb, gs, hv, hi);
        @(posedge clk);
        #1;
        got = {xpos, ypos, invader_enable, wave_cleared, invaders_landed, step_pulse};
        want = exp_q.pop_front();
        check("cycle", 64'(got), 64'(want));
        if (step_pulse) step_count++;
    endtask

    task automatic frame();
        cyc(1'b1, 1'b0, 1'b0, 4'd0);
        cyc(1'b1, 1'b0, 1'b0, 4'd0);
        cyc(1'b0, 1'b0, 1'b0, 4'd0);
        cyc(1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic wait_step(output int frames);
        frames = 0;
        step_count = 0;
        while (step_count == 0 && frames < 40) begin
            frame();
            frames++;
        end
    endtask

    hit_vec_t   hit_tab[6];
    march_vec_t march_tab[6];
    int         kill_list[6];

    initial begin
        int frames;
        hit_tab[0] = '{4'd3,  10'h3F7, 1};
        hit_tab[1] = '{4'd3,  10'h3F7, 1};
        hit_tab[2] = '{4'd12, 10'h3F7, 1};
        hit_tab[3] = '{4'd15, 10'h3F7, 1};
        hit_tab[4] = '{4'd0,  10'h3F6, 2};
        hit_tab[5] = '{4'd9,  10'h1F6, 3};
        march_tab[0] = '{8, 0, 0};
        march_tab[1] = '{16, 0, 0};
        march_tab[2] = '{16, 16, 0};
        march_tab[3] = '{8, 16, 0};
        march_tab[4] = '{0, 16, 0};
        march_tab[5] = '{0, 32, 1};
        kill_list = '{1, 2, 4, 5, 6, 7};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({xpos, ypos, invader_enable, wave_cleared, invaders_landed, step_pulse}), 64'(0));
        #3 rst_n = 1'b1;

        // Start, then 29 frames without a step, step on the 30th.
        cyc(1'b0, 1'b1, 1'b0, 4'd0);
        check("start_enable", 64'(invader_enable), 64'(10'h3FF));
        step_count = 0;
        repeat (29) frame();
        check("x_after_29", 64'(xpos), 64'(0));
        check("steps_after_29", 64'(step_count), 64'(0));
        frame();
        check("x_after_30", 64'(xpos), 64'(8));
        check("step_pulse_cycles", 64'(step_count), 64'(1));

        // Hit table
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0, 1'b1, hit_tab[i].idx);
            check("hit_enable", 64'(invader_enable), 64'(hit_tab[i].en));
            check("hit_kills", 64'(dut.kills_q), 64'(hit_tab[i].kills));
            cyc(1'b0, 1'b0, 1'b0, 4'd0);
        end

        // Kill down to one survivor: period becomes max(4, 30-18) = 12.
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 4'(kill_list[i]));
        end
        check("kills_9", 64'(dut.kills_q), 64'(9));
        wait_step(frames);
        check("period_12", 64'(frames), 64'(12));
        check("x_after_fast_step", 64'(xpos), 64'(16));

        // Kill the last invader: cleared, position frozen.
        cyc(1'b0, 1'b0, 1'b1, 4'd8);
        cyc(1'b0, 1'b0, 1'b0, 4'd0);
        cyc(1'b0, 1'b0, 1'b0, 4'd0);
        check("wave_cleared", 64'(wave_cleared), 64'(1));
        check("state_cleared", 64'(dut.state_q), 64'(invaders_pkg::CLEARED));
        repeat (5) frame();
        check("frozen_x", 64'(xpos), 64'(16));
        check("frozen_y", 64'(ypos), 64'(0));

        // Restart and march to the edges until landing.
        cyc(1'b0, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 6; i++) begin
            wait_step(frames);
            check("march_step_seen", 64'(step_count), 64'(1));
            check("march_x", 64'(xpos), 64'(march_tab[i].x));
            check("march_y", 64'(ypos), 64'(march_tab[i].y));
            check("march_landed", 64'(invaders_landed), 64'(march_tab[i].land));
        end
        check("state_landed", 64'(dut.state_q), 64'(invaders_pkg::LANDED));
        cyc(1'b0, 1'b0, 1'b1, 4'd0);
        cyc(1'b0, 1'b0, 1'b0, 4'd0);
        check("landed_hit_ignored", 64'(invader_enable), 64'(10'h3FF));
        cyc(1'b0, 1'b1, 1'b0, 4'd0);
        check("restart_outputs", 64'({xpos, ypos, invader_enable, wave_cleared, invaders_landed, step_pulse}),
              64'({10'd0, 10'd0, 10'h3FF, 3'b000}));

        // Asynchronous reset between edges, then idle for 100 frames.
        repeat (10) frame();
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", 64'({xpos, ypos, invader_enable, wave_cleared, invaders_landed, step_pulse}), 64'(0));
        model_reset();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) frame();
        check("idle_100_frames", 64'({xpos, ypos, invader_enable, wave_cleared, invaders_landed, step_pulse}), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
